// File: rtl/toags_word_packer.sv
// Serial-to-parallel word packer: samples qualified bits LSB-first into WIDTH-bit
// words and buffers them in a show-ahead FIFO; words arriving while full are dropped.
module toags_word_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_en,
  input  logic                     sync_clr,
  output logic [WIDTH-1:0]         word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [FILL_W-1:0] fill_d;
  logic [WIDTH-1:0]  head_d, push_word;
  logic              valid_d, overflow_d;
  logic [7:0]        drop_d;
  logic              push, pop, full, push_acc, drop, mem_we;

  // Next-state logic for packer, FIFO pointers, head register and status
  always_comb begin
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    push       = 1'b0;
    push_word  = {bit_in, shreg_q[WIDTH-2:0]};
    pop        = word_valid & word_ready;
    full       = (fill == FILL_W'(DEPTH));
    rd_d       = rd_q;
    wr_d       = wr_q;
    fill_d     = fill;
    overflow_d = overflow;
    drop_d     = drop_count;

    if (bit_en) begin
      shreg_d[cnt_q] = bit_in;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A full FIFO still accepts a word when the head leaves in the same cycle
    push_acc = push & (~full | pop);
    drop     = push & full & ~pop;
    mem_we   = push_acc & ~sync_clr;

    if (pop)      rd_d = rd_q + PTR_W'(1);
    if (push_acc) wr_d = wr_q + PTR_W'(1);

    case ({push_acc, pop})
      2'b10:   fill_d = fill + FILL_W'(1);
      2'b01:   fill_d = fill - FILL_W'(1);
      default: fill_d = fill;
    endcase

    head_d  = (push_acc && (wr_q == rd_d)) ? push_word : mem_q[rd_d];
    valid_d = (fill_d != '0);

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count != 8'hFF) drop_d = drop_count + 8'd1;
    end

    if (sync_clr) begin
      cnt_d      = '0;
      shreg_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      fill_d     = '0;
      head_d     = '0;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      shreg_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      fill       <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      fill       <= fill_d;
      word_data  <= head_d;
      word_valid <= valid_d;
      overflow   <= overflow_d;
      drop_count <= drop_d;
      if (sync_clr) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (mem_we) begin
        mem_q[wr_q] <= push_word;
      end
    end
  end

endmodule

// File: tb/tb_toags_word_packer.sv
// Directed bench for toags_word_packer: expected words are queued as stimulus is
// driven and compared against words observed crossing the valid/ready handshake.
module tb_toags_word_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_en, sync_clr, word_ready;
  logic [7:0] word_data;
  logic       word_valid;
  logic [1:0] fill;
  logic       overflow;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  toags_word_packer #(.WIDTH(8), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .sync_clr   (sync_clr),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fill       (fill),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Record each word that will transfer at the coming rising edge
  always @(negedge clk) begin
    if (rst && !sync_clr && word_valid && word_ready) got_q.push_back(word_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic v, input logic [1:0] f,
                            input logic o, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(word_valid), 32'(v));
    chk({tag, ".fill"}, 32'(fill), 32'(f));
    chk({tag, ".overflow"}, 32'(overflow), 32'(o));
    chk({tag, ".drops"}, 32'(drop_count), 32'(d));
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the rising edge
  task automatic cycle(input logic en, input logic b, input logic rdy, input logic sc);
    bit_en = en; bit_in = b; word_ready = rdy; sync_clr = sc;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic rdy);
    for (int i = 0; i < 8; i++) cycle(1'b1, v[i], rdy, 1'b0);
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] e, g;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        chk({tag, ".missing_word"}, 32'hFFFF_FFFF, 32'(e));
      end else begin
        g = got_q.pop_front();
        chk({tag, ".word"}, 32'(g), 32'(e));
      end
    end
    chk({tag, ".extra_words"}, 32'(got_q.size()), 32'd0);
    got_q.delete();
  endtask

  initial begin
    rst = 1'b0; bit_in = 1'b0; bit_en = 1'b0; sync_clr = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 1'b0, 2'd0, 1'b0, 8'd0);
    chk("reset.data", 32'(word_data), 32'd0);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Basic pack: 1,0,1,1,0,0,1,0 -> 8'h4D
    exp_q.push_back(8'h4D);
    send_byte(8'h4D, 1'b1);
    chk_status("basic.done", 1'b1, 2'd1, 1'b0, 8'd0);
    chk("basic.data", 32'(word_data), 32'h4D);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_status("basic.drained", 1'b0, 2'd0, 1'b0, 8'd0);
    sb_check("basic");

    // Overflow: third word dropped while two are buffered
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hA5, 1'b0);
    chk_status("ovf.full", 1'b1, 2'd2, 1'b1, 8'd1);
    chk("ovf.head", 32'(word_data), 32'hFF);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_status("ovf.drained", 1'b0, 2'd0, 1'b1, 8'd1);
    sb_check("ovf");

    // Full push+pop on the exact completing cycle: no drop
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk_status("clr1", 1'b0, 2'd0, 1'b0, 8'd0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'(8'h33 >> i), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk_status("pp.after", 1'b1, 2'd2, 1'b0, 8'd0);
    chk("pp.head", 32'(word_data), 32'h22);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_status("pp.drained", 1'b0, 2'd0, 1'b0, 8'd0);
    sb_check("pp");

    // Gaps: bit_en=0 cycles carry bit_in=1 and must be ignored
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'(8'h3C >> i), 1'b0, 1'b0);
      if (i == 6) chk("gap.partial_fill", 32'(fill), 32'd0);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk_status("gap.done", 1'b1, 2'd1, 1'b0, 8'd0);
    chk("gap.data", 32'(word_data), 32'h3C);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    sb_check("gap");

    // Reset mid-word with a buffered word outstanding
    send_byte(8'hE7, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rstmid.pre_valid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk_status("rstmid.async", 1'b0, 2'd0, 1'b0, 8'd0);
    chk("rstmid.data", 32'(word_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b0);
    chk_status("rstmid.word", 1'b1, 2'd1, 1'b0, 8'd0);
    chk("rstmid.word_data", 32'(word_data), 32'h81);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    sb_check("rstmid");

    // Flush: partial bits + one buffered word + overflow, cleared by sync_clr
    exp_q.push_back(8'h01);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_status("flush.pre", 1'b1, 2'd1, 1'b1, 8'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk_status("flush.post", 1'b0, 2'd0, 1'b0, 8'd0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b0);
    chk("flush.word_data", 32'(word_data), 32'h5A);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_status("flush.end", 1'b0, 2'd0, 1'b0, 8'd0);
    sb_check("flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/toags_word_packer.md
# toags_word_packer

Downstream deserialiser for the single-bit resumption-machine output stream. The block samples one output bit per qualified clock and packs bits LSB-first into WIDTH-bit words. It buffers completed words in a small show-ahead FIFO and presents them on a valid/ready port to the word-level consumer. The upstream machine has no backpressure, so words that arrive while the buffer is full are dropped and counted, never stalled.

## Interface
- WIDTH, 8, bits per packed word (2..32)
- DEPTH, 2, output FIFO entries (power of two, 2..16)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low: assertion (0) clears all state immediately; release is taken on clk
- bit_in  in  1  serial data bit from the upstream machine's output
- bit_en  in  1  qualifies bit_in for this cycle; tie to 1 when the upstream steps every cycle
- sync_clr  in  1  synchronous flush of packer, FIFO and status
- word_data  out  WIDTH  head-of-FIFO word; valid only when word_valid=1
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts the head word when word_valid & word_ready
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: at least one word has been dropped since reset or clear
- drop_count  out  8  dropped-word count, saturates at 255

## Operation
- Reset: all outputs are 0, and bit counter, shift register and FIFO pointers clear.
- Packing: a bit counter cnt runs 0..WIDTH-1. On each bit_en=1 cycle, shreg[cnt] <= bit_in and cnt advances. The first bit after reset or clear lands in word bit 0.
- Completion: on the bit_en cycle with cnt=WIDTH-1, the word {bit_in, shreg[WIDTH-2:0]} is pushed and cnt wraps to 0. The next bit starts a fresh word with no idle cycle.
- bit_en=0: no state change in the packer. The FIFO pop path still operates.
- Pop: occurs when word_valid & word_ready. The head advances, and word_data shows the next entry in the following cycle.
- Push when not full: the word is written at the tail.
- Push when full with no pop in the same cycle: the word is discarded, overflow <= 1 and drop_count increments (saturating at 255). FIFO contents are unchanged.
- Push when full with a pop in the same cycle: the push is accepted and fill is unchanged. No drop occurs.
- Push and pop together when not full: fill is unchanged.
- Pop when empty: ignored, because word_valid=0.
- sync_clr=1: next state equals reset state. It overrides bit_en, push and pop in the same cycle, so that cycle's bit is discarded and no pop is counted.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fill is a separate counter range-checked to 0..DEPTH.

## Timing
- Latency: word_valid rises in the cycle after the clock edge that samples the completing bit. Total latency from the first bit of a word is WIDTH cycles at bit_en=1.
- word_data and word_valid are registered and have no combinational path from bit_in or bit_en.
- word_ready affects state only at the clock edge. No output depends combinationally on word_ready.
- Sustained throughput: one word per WIDTH qualified cycles. With word_ready held high, the FIFO never exceeds fill=1.
- overflow and drop_count update in the cycle after the dropped push.
- Reset mid-word: a partial word is lost, and bits after reset release start at word bit 0.
- Reset mid-handshake: word_valid drops to 0 asynchronously. The consumer must not count that transfer.

## Test plan
- Basic pack: reset, ready=1, bit_en=1, bits 1,0,1,1,0,0,1,0 -> one cycle after the 8th bit, word_valid=1 with word_data=8'h4D for exactly one cycle. fill returns to 0.
- Overflow: ready=0, stream the bytes 8'hFF, 8'h00, 8'hA5 (LSB-first, 24 cycles) -> fill=2, overflow=1, drop_count=1. Then ready=1 pops 8'hFF then 8'h00, then word_valid=0.
- Full push+pop: FIFO full, ready pulses 1 on the exact cycle the third word completes -> no drop, and the sequence popped is word1, word2, word3 with drop_count=0.
- Gaps: bits of 8'h3C interleaved with bit_en=0 cycles carrying bit_in=1 -> word_data=8'h3C. Gap cycles change nothing.
- Reset mid-word: 5 bits sent, rst=0 for one cycle -> all outputs 0 immediately. The next 8 bits of 8'h81 yield exactly 8'h81.
- Flush: 3 bits sent plus one buffered word with overflow=1, then sync_clr=1 with bit_en=1 -> next cycle fill=0, overflow=0, drop_count=0. The following 8 bits of 8'h5A produce 8'h5A.
